// File: rtl/ps2_rx_pkg.sv
// ============================================================================
// Module : ps2_rx_pkg
// Brief  : Shared types and scancode constants for the PS/2 scancode receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module : ps2_frame_rx
// Brief  : Synchronises PS/2 lines, deframes 11-bit frames with timeout abort.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_rx
    import ps2_rx_pkg::*;
#(
    parameter int TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic         r_clk_s1, r_clk_s2, r_clk_prev;
    logic         r_dat_s1, r_dat_s2;
    frame_state_t r_state, w_state_nxt;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_shreg;
    logic         r_par_ok;
    logic [TW-1:0] r_tmo_cnt;
    logic         r_byte_valid, r_frame_err;

    logic w_edge, w_bit, w_timeout, w_frame_ok, w_frame_bad;

    assign w_edge    = r_clk_prev & ~r_clk_s2;
    assign w_bit     = r_dat_s2;
    // A falling edge in the same cycle always wins over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && !w_edge && (r_tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_edge) begin
            case (r_state)
                ST_IDLE:   if (!w_bit) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_frame_ok  = r_par_ok & w_bit;
                    w_frame_bad = ~(r_par_ok & w_bit);
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_clk_prev   <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 8'd0;
            r_par_ok     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_prev   <= r_clk_s2;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_state      <= w_state_nxt;
            r_byte_valid <= w_frame_ok;
            r_frame_err  <= w_frame_bad | w_timeout;
            if (w_edge) begin
                r_tmo_cnt <= '0;
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= 3'd0;
                    ST_DATA: begin
                        r_shreg   <= {w_bit, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_par_ok <= ^{r_shreg, w_bit};
                    default:   ;
                endcase
            end else if (r_state != ST_IDLE && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign rx_byte    = r_shreg;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
// ============================================================================
// Module : ps2_scancode_rx
// Brief  : PS/2 receiver folding E0/F0/E1 prefixes into key events.
//          Define PS2_RX_FIFO_EN for a buffered event FIFO with backpressure.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_rx
    import ps2_rx_pkg::*;
#(
    parameter int TIMEOUT    = 20000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_released,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       rx_error
);

    logic [7:0] w_byte;
    logic       w_byte_valid, w_frame_err;

    ps2_frame_rx #(.TIMEOUT(TIMEOUT)) u_frame (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (w_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err)
    );

    logic       r_ext_pend, r_rel_pend;
    logic [2:0] r_skip_cnt;
    logic       w_evt_valid;
    key_event_t w_evt;

    always_comb begin
        w_evt_valid = 1'b0;
        w_evt       = '0;
        if (w_byte_valid && r_skip_cnt == 3'd0) begin
            case (w_byte)
                PS2_EXT, PS2_REL: ;
                PS2_PAUSE: begin
                    w_evt_valid = 1'b1;
                    w_evt.code  = PS2_PAUSE;
                end
                default: begin
                    w_evt_valid = 1'b1;
                    w_evt.ext   = r_ext_pend;
                    w_evt.rel   = r_rel_pend;
                    w_evt.code  = w_byte;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
            r_skip_cnt <= 3'd0;
        end else if (w_frame_err) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (w_byte_valid) begin
            if (r_skip_cnt != 3'd0) begin
                r_skip_cnt <= r_skip_cnt - 3'd1;
            end else begin
                case (w_byte)
                    PS2_EXT:   r_ext_pend <= 1'b1;
                    PS2_REL:   r_rel_pend <= 1'b1;
                    // Pause's trailing 7 bytes carry no key information.
                    PS2_PAUSE: r_skip_cnt <= PAUSE_SKIP;
                    default: begin
                        r_ext_pend <= 1'b0;
                        r_rel_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    key_event_t r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_key_strobe, r_rx_error;
    logic        w_empty, w_full, w_pop, w_push, w_drop;
    key_event_t  w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && key_ready;
    assign w_push  = w_evt_valid && (!w_full || w_pop);
    assign w_drop  = w_evt_valid && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_evt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_key_strobe <= 1'b0;
            r_rx_error   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_key_strobe <= w_push;
            r_rx_error   <= w_frame_err | w_drop;
        end
    end

    assign key_valid    = !w_empty;
    assign key_code     = w_empty ? 8'd0 : w_head.code;
    assign key_ext      = w_empty ? 1'b0 : w_head.ext;
    assign key_released = w_empty ? 1'b0 : w_head.rel;
    assign key_strobe   = r_key_strobe;
    assign rx_error     = r_rx_error;
`else
    key_event_t r_key;
    logic       r_key_strobe, r_rx_error;
    logic       w_unused_cfg;

    assign w_unused_cfg = key_ready ^ (FIFO_DEPTH == 0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_key        <= '0;
            r_key_strobe <= 1'b0;
            r_rx_error   <= 1'b0;
        end else begin
            r_key_strobe <= w_evt_valid;
            r_rx_error   <= w_frame_err;
            if (w_evt_valid) r_key <= w_evt;
        end
    end

    assign key_valid    = r_key_strobe;
    assign key_code     = r_key.code;
    assign key_ext      = r_key.ext;
    assign key_released = r_key.rel;
    assign key_strobe   = r_key_strobe;
    assign rx_error     = r_rx_error;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
// ============================================================================
// Module : tb_ps2_scancode_rx
// Brief  : Directed self-checking bench for ps2_scancode_rx (PS2_RX_FIFO_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scancode_rx;

    localparam int TO   = 200;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe, key_ext, key_released, key_valid, rx_error;
    logic [7:0] key_code;
    logic       key_ready = 1'b1;

    ps2_scancode_rx #(.TIMEOUT(TO), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_released (key_released),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .rx_error     (rx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_stop = 0;
    int ev_cnt = 0;
    int rx_err_cnt = 0;
    int vs_mis = 0;
    logic [7:0] ev_code [64];
    logic       ev_ext  [64];
    logic       ev_rel  [64];
    int         ev_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && key_strobe) begin
            if (ev_cnt < 64) begin
                ev_code[ev_cnt] = key_code;
                ev_ext[ev_cnt]  = key_ext;
                ev_rel[ev_cnt]  = key_released;
                ev_cyc[ev_cnt]  = cyc;
            end
            ev_cnt++;
        end
        if (reset_n && rx_error) rx_err_cnt++;
`ifndef PS2_RX_FIFO_EN
        if (key_valid !== key_strobe) vs_mis++;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10) t_stop = cyc;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
        repeat (HALF) @(posedge clk);
    endtask

    int e0, r0;
    logic [7:0] pause_seq [8];
    logic [7:0] fifo_keys [5];

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        fifo_keys = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};

        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_strobe", key_strobe, 0);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_error", rx_error, 0);

        // Test 1: single make code with latency
        e0 = ev_cnt; r0 = rx_err_cnt;
        send_frame(8'h1C, 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t1_count", ev_cnt - e0, 1);
        check_eq("t1_code", ev_code[e0], 8'h1C);
        check_eq("t1_ext", ev_ext[e0], 0);
        check_eq("t1_rel", ev_rel[e0], 0);
        check_eq("t1_latency", ev_cyc[e0] - t_stop, 4);

        // Test 2: extended break
        e0 = ev_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t2_count", ev_cnt - e0, 1);
        check_eq("t2_code", ev_code[e0], 8'h74);
        check_eq("t2_ext", ev_ext[e0], 1);
        check_eq("t2_rel", ev_rel[e0], 1);

        // Test 3: parity error then recovery
        e0 = ev_cnt; r0 = rx_err_cnt;
        send_frame(8'h1C, 1'b1);
        repeat (5) @(posedge clk);
        check_eq("t3_err", rx_err_cnt - r0, 1);
        check_eq("t3_nostrobe", ev_cnt - e0, 0);
        send_frame(8'h32, 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t3_code", ev_code[e0], 8'h32);
        check_eq("t3_ext", ev_ext[e0], 0);
        check_eq("t3_rel", ev_rel[e0], 0);

        // Test 4: timeout mid-frame
        e0 = ev_cnt; r0 = rx_err_cnt;
        send_bits(11'b111_0101_0110, 5);
        repeat (TO + 20) @(posedge clk);
        check_eq("t4_err", rx_err_cnt - r0, 1);
        check_eq("t4_nostrobe", ev_cnt - e0, 0);
        send_frame(8'h1C, 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t4_count", ev_cnt - e0, 1);
        check_eq("t4_code", ev_code[e0], 8'h1C);

        // Test 5: pause sequence folded into one event
        e0 = ev_cnt;
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0);
        send_frame(8'h1C, 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t5_count", ev_cnt - e0, 2);
        check_eq("t5_code0", ev_code[e0], 8'hE1);
        check_eq("t5_ext0", ev_ext[e0], 0);
        check_eq("t5_rel0", ev_rel[e0], 0);
        check_eq("t5_code1", ev_code[e0 + 1], 8'h1C);
        check_eq("t5_flags1", {ev_ext[e0 + 1], ev_rel[e0 + 1]}, 0);

`ifdef PS2_RX_FIFO_EN
        // Test 6: FIFO fill, overflow drop, then ordered drain
        e0 = ev_cnt; r0 = rx_err_cnt;
        @(negedge clk); key_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(fifo_keys[i], 1'b0);
        repeat (5) @(posedge clk);
        check_eq("t6_pushes", ev_cnt - e0, 4);
        check_eq("t6_overflow", rx_err_cnt - r0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t6_valid", key_valid, 1);
            check_eq("t6_head", key_code, fifo_keys[i]);
            key_ready = 1'b1;
        end
        @(negedge clk);
        check_eq("t6_empty", key_valid, 0);
        check_eq("t6_empty_code", key_code, 0);
`else
        check_eq("valid_eq_strobe", vs_mis, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Core-side PS/2 receiver and scancode decoder sitting directly downstream of the host I/O block's emulated keyboard port (ps2_kbd_clk / ps2_kbd_data).
- Oversamples the slow PS/2 lines on the core clock and deframes 11-bit frames.
- Folds E0/F0/E1 prefixes into single key events for arcade input mapping.

Parameters:
TIMEOUT, 20000, core-clock cycles allowed between PS/2 falling edges inside a frame before abort
FIFO_DEPTH, 4, event FIFO entries (used only with PS2_RX_FIFO_EN; power of two)

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous, active-low reset
ps2_clk  in  1  PS/2 clock from host I/O (idle high)
ps2_data  in  1  PS/2 data from host I/O (idle high)
key_strobe  out  1  one-cycle pulse per decoded key event
key_code  out  8  scancode of event (prefixes removed)
key_ext  out  1  event was E0-prefixed
key_released  out  1  event was F0-prefixed (break)
key_valid  out  1  event available (see Optional Feature)
key_ready  in  1  consumer accepts event (see Optional Feature)
rx_error  out  1  one-cycle pulse: parity/stop/timeout/overflow error

Behaviour:
- Clocking: one clock `clk`; reset_n is synchronous and active-low.
- Reset: all outputs 0; sync flops 1; frame state IDLE; prefix flags, skip count, FIFO cleared. Reset mid-frame discards the partial byte.
- Sync: 2-FF synchroniser on ps2_clk and ps2_data.
- Falling edge = synced clk prev 1, now 0. Synced data is sampled in that cycle.
- Frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: edge with data=0 -> DATA, bit_cnt=0. Edge with data=1 -> ignored, no error.
  - DATA: shreg <= {d, shreg[7:1]} (LSB first). After 8th bit -> PARITY.
  - PARITY: store d; odd parity required (^shreg ^ d == 1).
  - STOP: d must be 1. If parity and stop are good -> byte_valid pulse in next cycle. Otherwise rx_error pulse, byte dropped, prefix flags cleared. Always -> IDLE.
- Timeout: counter ($clog2(TIMEOUT+1) bits) cleared on every falling edge; increments while state != IDLE. Reaching TIMEOUT-1 -> IDLE, rx_error pulse, prefix flags cleared. An edge in the same cycle takes priority (counter cleared, no timeout).
- Decoder, on byte_valid:
  - skip_cnt>0 -> skip_cnt-1, no event.
  - E0 -> ext_pend=1.
  - F0 -> rel_pend=1.
  - E1 -> event {code=E1, ext=0, rel=0}, skip_cnt=7.
  - Any other byte -> event {code, ext_pend, rel_pend}; both flags cleared.
  - AA/FA/EE etc. are passed through as ordinary codes.
- Latency: cycle N = synced edge sampling stop bit. byte_valid at N+1; key_strobe and outputs updated at N+2.
- key_code/key_ext/key_released hold the last event until the next one.

Optional Feature:
PS2_RX_FIFO_EN.
- Without: key_valid == key_strobe; key_ready ignored; no backpressure.
- With: FIFO_DEPTH x 10-bit FIFO of {ext, rel, code}.
  - key_valid = !empty. key_code/key_ext/key_released show the FIFO head.
  - Pop on key_valid && key_ready.
  - key_strobe pulses on each successful push.
  - Push when full with no pop in the same cycle -> event dropped, rx_error pulse.
  - Push and pop in the same cycle when full -> both happen, nothing dropped.
  - Empty: head outputs 0.

Decomposition:
- Package ps2_rx_pkg:
  - frame state enum;
  - constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1, PAUSE_SKIP=3'd7;
  - key_event_t struct {ext, rel, code[7:0]}.
- Sub-module ps2_frame_rx: synchroniser, edge detect, frame FSM, timeout. Outputs byte[7:0], byte_valid, frame_err.
- Top handles prefix decode, skip count and the optional FIFO.

Test Plan:
1. Frame 1C (parity bit 0, stop 1) -> one key_strobe: code=1C, ext=0, released=0, at N+2.
2. Frames E0, F0, 74 -> exactly one strobe: code=74, ext=1, released=1; no strobe on the prefixes.
3. Frame 1C with parity bit 1 -> rx_error pulse, no strobe. Then valid 32 -> code=32, ext=0, released=0.
4. Start bit + 4 data bits, then clock held high TIMEOUT cycles -> rx_error pulse, FSM IDLE. Next 1C frame decodes correctly.
5. Pause sequence E1 14 77 E1 F0 14 F0 77 then 1C -> exactly two events: E1, then 1C (ext=0, rel=0).
6. PS2_RX_FIFO_EN, key_ready=0, keys 15,16,1E,26,25 -> key_valid=1, fifth push raises rx_error. Then key_ready=1 -> pops 15,16,1E,26 in order, then key_valid=0.
